// File: rtl/accumulator.sv
// accumulator: sums COUNT unsigned WIDTH-bit operands per run, with a
// valid/ready operand input and a valid/ready result output.
// The result is held until downstream consumes it.
// Optional feature: define ACCUMULATOR_SAT_EN for saturating accumulation.
// Without it, the sum wraps modulo 2^WIDTH.
// In both builds, ovf records any carry-out seen during the run.

// Ripple-carry adder.
// Carry propagates bit by bit through a generated chain.
module rca #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_ci,
   output logic [WIDTH-1:0] o_s,
   output logic             o_co
);
   logic [WIDTH:0] w_c;

   assign w_c[0] = i_ci;

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_bit
         assign o_s[gi]    = i_a[gi] ^ i_b[gi] ^ w_c[gi];
         assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
      end
   endgenerate

   assign o_co = w_c[WIDTH];
endmodule

module accumulator #(
   parameter int WIDTH = 16,
   parameter int COUNT = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             ovf,
   output logic             busy
);
   // Counter must hold values 0..COUNT; never narrower than one bit.
   localparam int CNT_W = (COUNT < 2) ? 1 : $clog2(COUNT + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(COUNT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] w_add_sum;
   logic [WIDTH-1:0] w_acc_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_ovf;
   logic             w_co;
   logic             w_accept;
   logic             w_last;

   rca #(.WIDTH(WIDTH)) u_add (
      .i_a  (r_acc),
      .i_b  (in_data),
      .i_ci (1'b0),
      .o_s  (w_add_sum),
      .o_co (w_co)
   );

`ifdef ACCUMULATOR_SAT_EN
   // Clamp to all ones on carry.
   // A saturated value stays saturated for the rest of the run.
   // Any nonzero add on top of all ones carries out again.
   assign w_acc_next = w_co ? {WIDTH{1'b1}} : w_add_sum;
`else
   assign w_acc_next = w_add_sum;
`endif

   assign w_accept = in_valid & in_ready;
   assign w_last   = (r_cnt == LAST_IDX);
   assign sum      = r_acc;
   assign ovf      = r_ovf;

   // Next-state and handshake outputs, decoded from state only.
   always_comb begin
      w_state_next = r_state;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      busy         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_next = S_ACC;
         end
         S_ACC: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid && w_last) w_state_next = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            busy      = 1'b1;
            if (out_ready) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_next;
   end

   // Datapath: clear on run start, update on each accepted operand.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (r_state == S_IDLE && start) begin
         r_acc <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
      end else if (w_accept) begin
         r_acc <= w_acc_next;
         r_cnt <= r_cnt + 1'b1;
         r_ovf <= r_ovf | w_co;
      end
   end
endmodule

// File: tb/tb_accumulator.sv
// Directed bench for accumulator.
// Main instance is WIDTH=16, COUNT=4.
// A second instance with COUNT=1 covers the single-operand run.
module tb_accumulator;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [15:0] in_data = '0;
   logic        in_ready, out_valid, ovf, busy;
   logic [15:0] sum;

   logic        start1 = 1'b0, in_valid1 = 1'b0, out_ready1 = 1'b0;
   logic [15:0] in_data1 = '0;
   logic        in_ready1, out_valid1, ovf1, busy1;
   logic [15:0] sum1;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   accumulator #(.WIDTH(16), .COUNT(4)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .in_ready(in_ready), .in_data(in_data), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .ovf(ovf), .busy(busy)
   );

   accumulator #(.WIDTH(16), .COUNT(1)) dut1 (
      .clk(clk), .rst(rst), .start(start1), .in_valid(in_valid1),
      .in_ready(in_ready1), .in_data(in_data1), .out_valid(out_valid1),
      .out_ready(out_ready1), .sum(sum1), .ovf(ovf1), .busy(busy1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic put(input logic [15:0] d);
      in_valid = 1'b1;
      in_data  = d;
      cyc();
      in_valid = 1'b0;
      $display("accept operand %h -> acc %h", d, sum);
   endtask

   task automatic begin_run();
      start = 1'b1;
      cyc();
      start = 1'b0;
   endtask

   initial begin
      // Reset state
      #2;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sum", sum, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_busy", busy, 0);
      cyc();
      rst = 1'b0;
      cyc();
      chk("idle_in_ready", in_ready, 0);

      // Run 1: back-to-back 1,2,3,4 with out_ready held high
      out_ready = 1'b1;
      begin_run();
      chk("acc_in_ready", in_ready, 1);
      chk("acc_busy", busy, 1);
      put(16'd1); put(16'd2); put(16'd3);
      chk("r1_not_yet_valid", out_valid, 0);
      put(16'd4);
      chk("r1_out_valid", out_valid, 1);
      chk("r1_sum", sum, 16'h000A);
      chk("r1_ovf", ovf, 0);
      chk("r1_done_in_ready", in_ready, 0);
      cyc();
      chk("r1_back_idle_valid", out_valid, 0);
      chk("r1_back_idle_busy", busy, 0);
      $display("run1 result sum=%h ovf=%b", 16'h000A, 1'b0);

      // Run 2: carry-out on the first add
      begin_run();
      put(16'hFFFF); put(16'h0002); put(16'h0000); put(16'h0000);
      chk("r2_out_valid", out_valid, 1);
`ifdef ACCUMULATOR_SAT_EN
      chk("r2_sum_sat", sum, 16'hFFFF);
`else
      chk("r2_sum_wrap", sum, 16'h0001);
`endif
      chk("r2_ovf", ovf, 1);
      cyc();
      chk("r2_idle", busy, 0);

      // Run 3: gaps between operands, start pulses while busy, delayed out_ready
      out_ready = 1'b0;
      begin_run();
      put(16'd5);
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("r3_gap_sum_hold", sum, 16'd5);
      chk("r3_gap_busy", busy, 1);
      put(16'd6);
      repeat (3) cyc();
      chk("r3_gap3_sum_hold", sum, 16'd11);
      put(16'd7);
      repeat (2) cyc();
      put(16'd8);
      for (int i = 0; i < 5; i++) begin
         chk("r3_hold_valid", out_valid, 1);
         chk("r3_hold_sum", sum, 16'h001A);
         start = (i == 2);
         cyc();
      end
      start = 1'b0;
      chk("r3_still_valid", out_valid, 1);
      chk("r3_still_sum", sum, 16'h001A);
      chk("r3_ovf", ovf, 0);
      out_ready = 1'b1;
      start = 1'b1;
      cyc();
      start = 1'b0;
      chk("r3_idle_valid", out_valid, 0);
      chk("r3_idle_busy", busy, 0);
      cyc();
      chk("r3_no_restart", busy, 0);

      // Run 4: asynchronous reset mid-run, then a clean run
      begin_run();
      put(16'd1); put(16'd1);
      chk("r4_partial_sum", sum, 16'd2);
      #2 rst = 1'b1;
      #1;
      chk("r4_async_in_ready", in_ready, 0);
      chk("r4_async_out_valid", out_valid, 0);
      chk("r4_async_sum", sum, 0);
      chk("r4_async_ovf", ovf, 0);
      chk("r4_async_busy", busy, 0);
      cyc();
      rst = 1'b0;
      cyc();
      chk("r4_post_rst_idle", busy, 0);
      begin_run();
      put(16'd1); put(16'd1); put(16'd1); put(16'd1);
      chk("r4_out_valid", out_valid, 1);
      chk("r4_sum", sum, 16'h0004);
      chk("r4_ovf", ovf, 0);
      cyc();

      // COUNT=1 instance: one operand completes the run
      start1 = 1'b1;
      cyc();
      start1 = 1'b0;
      chk("c1_in_ready", in_ready1, 1);
      in_valid1 = 1'b1;
      in_data1  = 16'h1234;
      cyc();
      in_valid1 = 1'b0;
      chk("c1_out_valid", out_valid1, 1);
      chk("c1_sum", sum1, 16'h1234);
      chk("c1_ovf", ovf1, 0);
      out_ready1 = 1'b1;
      cyc();
      chk("c1_idle", out_valid1, 0);
      $display("count1 result sum=%h", 16'h1234);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/accumulator.md
ACCUMULATOR -- requirements
Module: accumulator

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 Parameter COUNT, default 8: operands summed per run; legal range 1..65535.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  begin a new run; sampled only in IDLE.
REQ-006 in_valid  input  1  in_data carries a valid operand.
REQ-007 in_ready  output  1  block accepts an operand this cycle.
REQ-008 in_data  input  WIDTH  unsigned operand.
REQ-009 out_valid  output  1  sum and ovf are valid.
REQ-010 out_ready  input  1  downstream accepts the result.
REQ-011 sum  output  WIDTH  accumulated result.
REQ-012 ovf  output  1  sticky flag: at least one addition produced carry-out this run.
REQ-013 busy  output  1  high in ACC and DONE.

Function
REQ-014 The block SHALL compute acc + in_data through one instance of the team's ripple-carry adder (WIDTH-wide, cin tied 0), using its co as the overflow indication.
REQ-015 FSM states SHALL be IDLE, ACC, DONE; encoding is free.
REQ-016 IDLE: in_ready=0, out_valid=0, busy=0; start=1 -> acc<=0, cnt<=0, ovf<=0, next ACC.
REQ-017 ACC: in_ready=1 combinationally from state only, never from in_valid.
REQ-018 Accept = in_valid & in_ready; on accept, acc <= adder out, cnt <= cnt+1, ovf <= ovf | co.
REQ-019 Accept with cnt==COUNT-1 SHALL move to DONE; sum valid on the next cycle (1-cycle latency from last accept).
REQ-020 Cycles with in_valid=0 in ACC SHALL change no state.
REQ-021 DONE: out_valid=1, in_ready=0; sum and ovf SHALL stay stable until out_ready=1, then next IDLE.
REQ-022 start SHALL be ignored in ACC and DONE, including the DONE cycle where out_ready=1.
REQ-023 sum SHALL equal acc in all states; it is meaningful only while out_valid=1.
REQ-024 cnt width SHALL be ceil(log2(COUNT+1)), minimum 1; COUNT=1 SHALL finish after a single accept.
REQ-025 Without saturation, addition wraps modulo 2^WIDTH.

Reset
REQ-026 rst=1 SHALL force IDLE, acc=0, cnt=0, ovf=0 immediately, independent of clk.
REQ-027 Reset values: in_ready=0, out_valid=0, sum=0, ovf=0, busy=0.
REQ-028 Reset during ACC or DONE SHALL discard the partial or unconsumed result; the first edge after release starts in IDLE.

Configuration
REQ-029 Macro ACCUMULATOR_SAT_EN SHALL select saturating accumulation.
REQ-030 Defined: on co=1, acc <= all ones (2^WIDTH-1), ovf <= 1; once saturated, acc stays all ones for the rest of the run.
REQ-031 Undefined: acc <= adder out (wrap), ovf still set on co.

Verification (WIDTH=16, COUNT=4)
REQ-032 start; feed 1,2,3,4 back-to-back, out_ready=1 -> out_valid one cycle after 4th accept, sum=0x000A, ovf=0, then IDLE.
REQ-033 Feed 0xFFFF,0x0002,0x0000,0x0000 -> without macro sum=0x0001, ovf=1; with ACCUMULATOR_SAT_EN sum=0xFFFF, ovf=1.
REQ-034 Feed 5,6,7,8 with in_valid gaps of 0-3 cycles; hold out_ready=0 for 5 cycles -> sum=0x001A stable and out_valid=1 throughout; IDLE the cycle after out_ready=1.
REQ-035 Assert rst asynchronously after 2 accepts -> all outputs 0 before next edge; new run 1,1,1,1 -> sum=0x0004, ovf=0.
REQ-036 Pulse start in ACC and together with out_ready in DONE -> no restart, run count unaffected; COUNT=1 build: single operand 0x1234 -> sum=0x1234.
